sprite_line_scheduler: RTL
==========================

# sprite_line_scheduler

Per-scanline sprite scheduler for the sprite graphics pipeline. During horizontal blanking it scans the sprite register bank once and evaluates every entry against the upcoming line. It then loads up to SLOTS visible sprites, lowest register index first, into a slot table used by the pixel path during the next active line. The per-pixel comparators then only examine SLOTS entries instead of the whole bank, and the bank needs a single shared read port.

## Interface
- NUM_REGS, 32, number of sprite registers scanned (power of two, index width AW = log2(NUM_REGS))
- SLOTS, 4, sprites retained per line
- SIZE_REG, 32, sprite register width
- SPRITE_LINE, 20, sprite height offset; a sprite covers rows y..y+SPRITE_LINE inclusive
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse at hblank start; ignored while busy
- next_line  in  10  y coordinate of the upcoming line; latched on accepted start
- rf_addr  out  AW  sprite bank read address
- rf_data  in  SIZE_REG  bank read data; synchronous RAM, valid one cycle after rf_addr
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse; slot outputs updated on the same edge
- overflow  out  1  more than SLOTS hits on the last completed line
- slot_valid  out  SLOTS  slot holds a sprite
- slot_x  out  SLOTS*10  x field (bits 28:19) per slot
- slot_row  out  SLOTS*5  next_line − y, range 0..SPRITE_LINE
- slot_idx  out  SLOTS*AW  register index per slot
- slot_attr  out  SLOTS*9  bits 8:0 of the register, passed through

## Operation
- Register fields: bit 29 active, 28:19 x, 18:9 y, 8:0 attr; other bits are ignored.
- Hit condition: active==1 && next_line >= y && next_line <= y+SPRITE_LINE. The sum is computed at 11 bits, with no wrap. A sprite at y=1015 therefore covers lines 1015..1023 only.
- States:
  - IDLE: on start, latch next_line, clear the shadow table, and go to SCAN.
  - SCAN: rf_addr increments 0..NUM_REGS-1, one per cycle. Each returned word is evaluated one cycle later. A hit is written to the first free shadow slot.
  - COMMIT: copy the shadow table to the outputs, pulse done, and go to IDLE.
- Slot order matches ascending register index. Unused slots have valid=0, and their fields are 0.
- On a hit with all shadow slots full, no slot is written and the internal overflow flag is set. The scan still runs to completion, so timing is fixed.
- Output tables, including overflow, stay stable between commits. The outputs are double-buffered, so the pixel path never sees a partial table.

## Timing
- Reset values: rf_addr=0, busy=0, done=0, overflow=0, all slot outputs 0. The state is IDLE.
- start is sampled at edge E0.
- rf_addr=k during the cycle after edge E(k). rf_data for k is evaluated in the cycle after E(k+1).
- The last evaluation is registered at E(NUM_REGS+1). The commit happens at that edge, with done high for the following cycle.
- Latency from start to done is NUM_REGS+1 cycles. busy is high from E0 until the commit edge.
- Back-to-back: a start in the cycle where done is high is accepted.
- start while busy is ignored; the latched next_line does not change.
- Reset mid-scan returns all outputs to their reset values immediately. The previous line's table is lost.

## Structure
- The shared package sprite_pkg holds:
  - field positions (ACTIVE_BIT, X_HI/LO, Y_HI/LO, ATTR_HI/LO) and SPRITE_LINE, so the comparator and scheduler agree;
  - a slot record typedef.
- Sub-module sprite_row_match is combinational: register word plus line in, hit and row out.
- The top level holds the FSM, address counter, slot-fill pointer, and shadow and output tables.

## Test plan
- Single hit: reg 5 = active, x=100, y=50; next_line=60 → done at start+33; slot0 valid, x=100, row=10, idx=5; other slots invalid; overflow=0.
- Boundaries: y=50 with next_line=49, 50, 70 and 71 → hit at 50 (row 0) and 70 (row 20) only. A register with active=0 and a matching y → no hit.
- Overflow and priority: regs 3, 7, 9, 12 and 20 all hit → slots hold idx 3, 7, 9, 12, and overflow=1. The next line with no hits → all invalid, overflow=0.
- Top-edge limit: y=1015, next_line=1023 → hit with row 8. A second case with y=1015 and a small next_line such as 4 → no hit, confirming no wrap.
- Handshake: start pulsed mid-scan with a different next_line → ignored, and the result reflects the first line. start in the done cycle → second scan accepted, and done follows 33 cycles later.
- Reset asserted at cycle 10 of a scan → outputs zero at once, no done pulse. A new start after release → normal result.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite line scheduler.
// Holds the sprite register field layout, the sprite height offset, the
// scheduler FSM state type and the per-slot record so the comparator and
// the scheduler always agree on field positions.
package sprite_pkg;

    // Sprite register field layout
    localparam int ACTIVE_BIT  = 29;
    localparam int X_HI        = 28;
    localparam int X_LO        = 19;
    localparam int Y_HI        = 18;
    localparam int Y_LO        = 9;
    localparam int ATTR_HI     = 8;
    localparam int ATTR_LO     = 0;

    // A sprite covers rows y .. y+SPRITE_LINE inclusive
    localparam int SPRITE_LINE = 20;

    localparam int LINE_W = 10;
    localparam int X_W    = X_HI - X_LO + 1;
    localparam int ROW_W  = 5;
    localparam int ATTR_W = ATTR_HI - ATTR_LO + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT
    } sched_state_t;

    // One slot of the shadow/output table (register index kept separately,
    // its width depends on the bank size)
    typedef struct packed {
        logic              valid;
        logic [X_W-1:0]    x;
        logic [ROW_W-1:0]  row;
        logic [ATTR_W-1:0] attr;
    } slot_rec_t;

endpackage

// File: rtl/sprite_row_match.sv
// sprite_row_match: combinational visibility test of one sprite register
// against one scanline.
//   word : sprite register contents
//   line : y coordinate of the line being scheduled
//   hit  : sprite is active and covers the line
//   row  : line - y (row inside the sprite), meaningful only when hit
module sprite_row_match
    import sprite_pkg::*;
#(
    parameter int SIZE_REG = 32,
    parameter int HEIGHT   = SPRITE_LINE
) (
    input  logic [SIZE_REG-1:0] word,
    input  logic [LINE_W-1:0]   line,
    output logic                hit,
    output logic [ROW_W-1:0]    row
);

    logic [LINE_W-1:0] y;
    logic [LINE_W:0]   y_end;
    logic [LINE_W-1:0] diff;
    logic              unused_bits;

    assign y     = word[Y_HI:Y_LO];
    // One extra bit so sprites near the bottom edge do not wrap to line 0
    assign y_end = {1'b0, y} + (LINE_W+1)'(HEIGHT);
    assign diff  = line - y;

    assign hit = word[ACTIVE_BIT] && (line >= y) && ({1'b0, line} <= y_end);
    assign row = diff[ROW_W-1:0];

    // Bits outside the field layout, plus the upper difference bits that are
    // zero whenever hit is set
    assign unused_bits = ^{word[SIZE_REG-1:ACTIVE_BIT+1], diff[LINE_W-1:ROW_W]};

endmodule

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: hblank sprite scan. On start it walks the sprite
// bank once through a single synchronous read port, evaluates each entry
// against the latched next_line and fills up to SLOTS shadow slots in
// ascending register order. The shadow table is copied to the output table
// in one edge at commit, so the pixel path never sees a partial table.
//   clk, reset     : clock, asynchronous active-high reset
//   start          : hblank pulse, ignored while busy
//   next_line      : line to schedule, latched on accepted start
//   rf_addr/rf_data: bank read port (data one cycle after address)
//   busy, done     : scan in progress / one-cycle commit pulse
//   overflow       : more than SLOTS hits on the last committed line
//   slot_*         : committed per-slot table, flattened slot 0 in LSBs
module sprite_line_scheduler
    import sprite_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int SLOTS    = 4,
    parameter int SIZE_REG = 32,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LINE_W-1:0]      next_line,
    output logic [AW-1:0]          rf_addr,
    input  logic [SIZE_REG-1:0]    rf_data,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [SLOTS-1:0]       slot_valid,
    output logic [SLOTS*X_W-1:0]   slot_x,
    output logic [SLOTS*ROW_W-1:0] slot_row,
    output logic [SLOTS*AW-1:0]    slot_idx,
    output logic [SLOTS*ATTR_W-1:0] slot_attr
);

    localparam int FW = $clog2(SLOTS + 1);

    sched_state_t state_q, state_d;
    logic [AW-1:0]     addr_q;
    logic [AW-1:0]     eval_idx_q;   // index whose data is on rf_data
    logic              eval_q;       // rf_data carries a word to evaluate
    logic [LINE_W-1:0] line_q;
    logic [FW-1:0]     fill_q, fill_d;
    logic              ovf_sh_q, ovf_sh_d;

    slot_rec_t [SLOTS-1:0]         sh_q, sh_d;
    logic [SLOTS-1:0][AW-1:0]      sh_idx_q, sh_idx_d;
    slot_rec_t [SLOTS-1:0]         out_q;
    logic [SLOTS-1:0][AW-1:0]      out_idx_q;
    logic                          ovf_q;
    logic                          done_q;

    logic             hit;
    logic [ROW_W-1:0] row;
    logic             accept;

    sprite_row_match #(
        .SIZE_REG (SIZE_REG),
        .HEIGHT   (SPRITE_LINE)
    ) u_match (
        .word (rf_data),
        .line (line_q),
        .hit  (hit),
        .row  (row)
    );

    assign accept = (state_q == ST_IDLE) && start;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SCAN;
            ST_SCAN:   if (addr_q == AW'(NUM_REGS - 1)) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Shadow table update; the commit edge copies sh_d so the final
    // evaluation lands in the same edge as the commit.
    always_comb begin
        sh_d     = sh_q;
        sh_idx_d = sh_idx_q;
        fill_d   = fill_q;
        ovf_sh_d = ovf_sh_q;
        if (accept) begin
            sh_d     = '0;
            sh_idx_d = '0;
            fill_d   = '0;
            ovf_sh_d = 1'b0;
        end else if (eval_q && hit) begin
            if (fill_q < FW'(SLOTS)) begin
                for (int s = 0; s < SLOTS; s++) begin
                    if (fill_q == FW'(s)) begin
                        sh_d[s].valid = 1'b1;
                        sh_d[s].x     = rf_data[X_HI:X_LO];
                        sh_d[s].row   = row;
                        sh_d[s].attr  = rf_data[ATTR_HI:ATTR_LO];
                        sh_idx_d[s]   = eval_idx_q;
                    end
                end
                fill_d = fill_q + FW'(1);
            end else begin
                ovf_sh_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            eval_idx_q <= '0;
            eval_q     <= 1'b0;
            line_q     <= '0;
            fill_q     <= '0;
            ovf_sh_q   <= 1'b0;
            sh_q       <= '0;
            sh_idx_q   <= '0;
            out_q      <= '0;
            out_idx_q  <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            eval_q     <= (state_q == ST_SCAN);
            eval_idx_q <= addr_q;
            addr_q     <= (state_q == ST_SCAN) ? addr_q + AW'(1) : '0;
            if (accept) line_q <= next_line;
            fill_q     <= fill_d;
            ovf_sh_q   <= ovf_sh_d;
            sh_q       <= sh_d;
            sh_idx_q   <= sh_idx_d;
            done_q     <= (state_q == ST_COMMIT);
            if (state_q == ST_COMMIT) begin
                out_q     <= sh_d;
                out_idx_q <= sh_idx_d;
                ovf_q     <= ovf_sh_d;
            end
        end
    end

    assign rf_addr  = addr_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign overflow = ovf_q;

    for (genvar s = 0; s < SLOTS; s++) begin : g_flat
        assign slot_valid[s]                 = out_q[s].valid;
        assign slot_x[s*X_W +: X_W]          = out_q[s].x;
        assign slot_row[s*ROW_W +: ROW_W]    = out_q[s].row;
        assign slot_attr[s*ATTR_W +: ATTR_W] = out_q[s].attr;
        assign slot_idx[s*AW +: AW]          = out_idx_q[s];
    end

endmodule
